axi_wrr_arbiter: RTL
====================

Name: axi_wrr_arbiter

Overview:
- N-way weighted round-robin arbiter with grant locking, for the AXI-Lite interconnect.
- Sits in front of a shared slave port and selects one master per transaction.
- Each requester may win up to its weight of consecutive transactions before priority rotates.
- A mode input switches to fixed priority.
- The grant is registered and held until the transaction handshake completes.

Parameters:
N, 4, number of requesters (N >= 2)
WEIGHT_W, 4, width of each per-requester weight field
ID_W, $clog2(N), derived; width of grant_id (not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N  request vector, one bit per requester
weight  in  N*WEIGHT_W  per-requester weight; field i = bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static
mode  in  1  0 = weighted round-robin, 1 = fixed priority (lowest index wins)
handshake_complete  in  1  granted transaction finished this cycle
grant  out  N  one-hot grant, registered
grant_valid  out  1  grant != 0
grant_id  out  ID_W  index of the granted requester; 0 when grant_valid = 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - grant = 0, grant_valid = 0, grant_id = 0.
  - state = IDLE, cur (priority pointer) = 0, cnt (credit) = 0.
- Effective weight: eff_w[i] = weight[i], or 1 when weight[i] == 0.
- cnt = 0 means "not loaded; use eff_w of the winner".
- State IDLE:
  - grant = 0.
  - If req != 0, pick winner w, register grant = onehot(w) and grant_id = w, go to LOCKED.
  - Latency: req seen at edge t gives grant visible after edge t+1.
- Winner selection in mode 0: first set bit of req scanning cur, cur+1, …, cur+N-1 (mod N). cur itself is included.
- Winner selection in mode 1: lowest set index of req.
- mode is sampled only in IDLE; a change while LOCKED has no effect on the held grant.
- State LOCKED:
  - grant, grant_id and grant_valid are held constant regardless of req.
  - The requester must keep req asserted (AXI VALID rule). If req[w] drops, the grant is still held.
  - handshake_complete while LOCKED: grant clears on the next edge, state returns to IDLE.
  - Minimum spacing between grants is therefore one idle cycle. Handshake at edge t gives grant = 0 after t+1 and a new grant earliest after t+2.
  - This avoids re-arbitrating on the stale VALID of the completing master.
- Credit update, mode 0 only, on handshake with winner w:
  - used = cnt if (w == cur and cnt != 0), else eff_w[w].
  - If used > 1: cur = w, cnt = used - 1.
  - Else: cur = (w+1) mod N, cnt = eff_w[(w+1) mod N].
- In mode 1, cur and cnt are not updated.
- handshake_complete in IDLE is ignored: no state, pointer or credit change.
- Wrap: cur = N-1 rotates to 0.
- Width rules:
  - cnt is WEIGHT_W bits and never underflows; the reload value is always >= 1.
  - grant_id is ID_W bits, zero-extended index.
- Reset mid-LOCKED: grant drops immediately (asynchronous); pointer and credit return to their reset values.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid == |grant.
  - A grant bit is only ever set for a requester whose req was high in the IDLE cycle where it was selected.

Decomposition:
- Package axi_arb_pkg holds:
  - arb_state_e enum: IDLE, LOCKED.
  - arb_mode_e enum: ARB_WRR = 0, ARB_FIXED = 1.
  - Helper function eff_weight (maps 0 to 1).
- One natural sub-module: arb_rot_ffs.
  - Combinational rotate-and-find-first.
  - Inputs: req vector and start index. Outputs: found flag and index.
  - Used for both modes; mode 1 passes start = 0.

Test Plan:
- Reset, then req=4'b1111, weights all 1, mode 0, handshake one cycle after each grant: grant order 0,1,2,3,0; one grant=0 cycle between grants; grant_id tracks the granted index.
- weight[0]=3, weight[1]=1, others 1, req=4'b0011 constant: grant sequence 0,0,0,1,0,0,0,1.
- weight[2]=0, req=4'b0100 only: grant 2 on every transaction; a zero weight behaves as 1; no lockup.
- Grant to requester 1 held 10 cycles without handshake while req toggles to 4'b1000: grant stays 4'b0010 until handshake_complete, then the next grant is 3.
- mode=1, req=4'b1110 repeatedly: always grant 1; then switch to mode=0: rotation resumes from the unchanged cur/cnt state.
- Assert rst_n low mid-LOCKED: grant = 0 with no clock edge needed; after release with req=4'b1111, first grant is 0; handshake_complete pulsed in IDLE changes nothing.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI-Lite weighted round-robin arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_e - arbiter FSM states (IDLE, LOCKED)
//   arb_mode_e  - arbitration policy (ARB_WRR = weighted RR, ARB_FIXED = lowest index)
//   eff_weight  - maps a zero weight to 1 so every requester always gets a turn
package axi_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_WRR   = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Weights are passed zero-extended to 32 bits; the caller truncates back to
  // its own field width. Never returns 0, so credit reloads are always >= 1.
  function automatic logic [31:0] eff_weight(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/arb_rot_ffs.sv
// Rotating find-first-set: first set bit of req_i scanning start_i, start_i+1, ... (mod N).
// Latency: purely combinational.
// Backpressure: n/a (no handshake).
//
// Ports:
//   req_i   [N-1:0]    request vector
//   start_i [ID_W-1:0] index scanned first (included in the scan)
//   found_o            at least one request is set
//   idx_o   [ID_W-1:0] index of the winning request, 0 when none found
module arb_rot_ffs #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] start_i,
  output logic            found_o,
  output logic [ID_W-1:0] idx_o
);

  logic [ID_W-1:0] pos;

  // Scan from the farthest offset back to the start so the closest hit to
  // start_i is the last one written and therefore wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = ID_W'((int'(start_i) + k) % N);
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/axi_wrr_arbiter.sv
// N-way weighted round-robin / fixed-priority arbiter with grant locking for a shared AXI-Lite slave.
// Latency: req seen at an IDLE edge gives a registered grant after that edge; grant clears one edge after handshake.
// Backpressure: grant is held until handshake_complete; at least one idle cycle separates consecutive grants.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[N-1:0]          request vector (AXI VALID per master)
//   weight[N*WEIGHT_W]  per-requester weights, field i = [i*WEIGHT_W +: WEIGHT_W], 0 behaves as 1
//   mode                0 = weighted round-robin, 1 = fixed priority (lowest index)
//   handshake_complete  granted transaction finished this cycle
//   grant[N-1:0]        registered one-hot grant
//   grant_valid         grant != 0
//   grant_id[ID_W-1:0]  index of granted requester, 0 when idle
module axi_wrr_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int ID_W     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  mode,
  input  logic                  handshake_complete,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id
);

  arb_state_e           state_q, state_d;
  arb_mode_e            mode_q, mode_d;
  logic [ID_W-1:0]      cur_q, cur_d;
  logic [WEIGHT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [ID_W-1:0]      gid_q, gid_d;

  logic [WEIGHT_W-1:0]  eff_w [N];
  logic [ID_W-1:0]      ffs_start;
  logic                 ffs_found;
  logic [ID_W-1:0]      ffs_idx;
  logic [WEIGHT_W-1:0]  used;
  logic [ID_W-1:0]      next_idx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff_w[i] = WEIGHT_W'(eff_weight(32'(weight[i*WEIGHT_W +: WEIGHT_W])));
    end
  end

  // Fixed priority is just a rotating scan that always starts at index 0.
  assign ffs_start = (arb_mode_e'(mode) == ARB_FIXED) ? '0 : cur_q;

  arb_rot_ffs #(
    .N    (N),
    .ID_W (ID_W)
  ) u_ffs (
    .req_i   (req),
    .start_i (ffs_start),
    .found_o (ffs_found),
    .idx_o   (ffs_idx)
  );

  // Credit in use for the current winner: a loaded count only applies while
  // the winner is still the pointer owner; otherwise start from its full weight.
  assign used     = ((gid_q == cur_q) && (cnt_q != '0)) ? cnt_q : eff_w[gid_q];
  assign next_idx = (gid_q == ID_W'(N - 1)) ? '0 : gid_q + ID_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        gid_d   = '0;
        if (ffs_found) begin
          grant_d          = '0;
          grant_d[ffs_idx] = 1'b1;
          gid_d            = ffs_idx;
          mode_d           = arb_mode_e'(mode);
          state_d          = LOCKED;
        end
      end
      LOCKED: begin
        // Returning to IDLE for a cycle keeps the completing master's stale
        // VALID from winning a second back-to-back transaction.
        if (handshake_complete) begin
          state_d = IDLE;
          grant_d = '0;
          gid_d   = '0;
          if (mode_q == ARB_WRR) begin
            if (used > WEIGHT_W'(1)) begin
              cur_d = gid_q;
              cnt_d = used - WEIGHT_W'(1);
            end else begin
              cur_d = next_idx;
              cnt_d = eff_w[next_idx];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gid_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ARB_WRR;
      cur_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;

endmodule
